// File: rtl/fpnew_lane_result_packer.sv
// Packs per-lane scalar FP results from a lane-serialised unit into one
// SIMD result word with a valid/ready output handshake.
// Ports: clk_i/rst_ni (async active-low); lane_*_i, vectorial_op_i, tag_i,
// in_valid_i/in_ready_o beat input; flush_i; result_o, status_o,
// extension_bit_o, tag_o, out_valid_o/out_ready_i packed output; busy_o.
// Option: FPNEW_PACKER_FAST_RELEASE_EN lets a new vector start in the
// same cycle the packed result is handed off.

package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned num_lanes(int unsigned width,
                                              fp_format_e fmt,
                                              logic vec);
        int unsigned n;
        n = width / fp_width(fmt);
        if (!vec || n == 0) return 1;
        return n;
    endfunction

endpackage

module fpnew_lane_result_packer #(
    parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::fp_format_e'(0),
    parameter int unsigned Width = 32,
    parameter logic EnableVectors = 1'b1,
    parameter type TagType = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [fpnew_pkg::fp_width(FpFormat)-1:0] lane_result_i,
    input  fpnew_pkg::status_t   lane_status_i,
    input  logic                 lane_mask_i,
    input  logic                 lane_ext_bit_i,
    input  logic                 lane_last_i,
    input  logic                 vectorial_op_i,
    input  TagType               tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [Width-1:0]     result_o,
    output fpnew_pkg::status_t   status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned FP_WIDTH  = fpnew_pkg::fp_width(FpFormat);
    localparam int unsigned NUM_LANES =
        fpnew_pkg::num_lanes(Width, FpFormat, EnableVectors);
    localparam int unsigned LANE_BITS =
        (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NUM_LANES-1:0][FP_WIDTH-1:0] storage_q;
    logic [NUM_LANES-1:0]               filled_q;
    logic [LANE_BITS-1:0]               cnt_q;
    fpnew_pkg::status_t                 status_q;
    logic                               ext_q;
    logic                               vec_q;
    TagType                             tag_q;

    logic       accept;
    logic       start;
    logic       first_done;
    logic       collect_done;
    logic [4:0] masked_status;

    assign masked_status = lane_status_i & {5{lane_mask_i}};

`ifdef FPNEW_PACKER_FAST_RELEASE_EN
    assign in_ready_o = (state_q != FULL) || out_ready_i;
`else
    assign in_ready_o = (state_q != FULL);
`endif

    assign accept = in_valid_i && in_ready_o;
    // Any beat not landing in COLLECT opens a fresh vector at lane 0.
    assign start  = accept && (state_q != COLLECT);

    assign first_done   = !vectorial_op_i || lane_last_i || (NUM_LANES == 1);
    assign collect_done = lane_last_i || (cnt_q == LAST_LANE) || !vec_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) state_d = first_done ? FULL : COLLECT;
                end
                COLLECT: begin
                    if (accept && collect_done) state_d = FULL;
                end
                FULL: begin
                    if (out_ready_i) begin
                        if (accept) state_d = first_done ? FULL : COLLECT;
                        else        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            storage_q <= '0;
            filled_q  <= '0;
            cnt_q     <= '0;
            status_q  <= '0;
            ext_q     <= 1'b0;
            vec_q     <= 1'b0;
            tag_q     <= '0;
        end else if (flush_i) begin
            filled_q <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else if (start) begin
            storage_q[0] <= lane_result_i;
            filled_q     <= NUM_LANES'(1);
            status_q     <= masked_status;
            ext_q        <= lane_ext_bit_i;
            vec_q        <= vectorial_op_i;
            tag_q        <= tag_i;
            cnt_q        <= first_done ? '0 : LANE_BITS'(1);
        end else if (accept) begin
            storage_q[cnt_q] <= lane_result_i;
            filled_q[cnt_q]  <= 1'b1;
            status_q         <= status_q | masked_status;
            cnt_q            <= collect_done ? '0 : cnt_q + LANE_BITS'(1);
        end else if (state_q == FULL && out_ready_i) begin
            filled_q <= '0;
            cnt_q    <= '0;
        end
    end

    // Unfilled lanes and any bits above the last lane carry the box bit.
    always_comb begin
        result_o = {Width{ext_q}};
        for (int i = 0; i < NUM_LANES; i++) begin
            result_o[i*FP_WIDTH +: FP_WIDTH] =
                filled_q[i] ? storage_q[i] : {FP_WIDTH{ext_q}};
        end
    end

    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign out_valid_o     = (state_q == FULL);
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpnew_lane_result_packer.sv
// Directed bench for fpnew_lane_result_packer: FP16 lanes, 64-bit word.
// Expected packed results queue up at stimulus time, checked on handshake.

module tb_fpnew_lane_result_packer;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        logic        ext;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_ni;
    logic [15:0] lane_result;
    logic [4:0]  lane_status;
    logic        lane_mask;
    logic        lane_ext;
    logic        lane_last;
    logic        vec_op;
    logic [3:0]  tag_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] result;
    logic [4:0]  status;
    logic        ext_out;
    logic [3:0]  tag_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hs_count = 0;

    fpnew_lane_result_packer #(
        .FpFormat      (fpnew_pkg::FP16),
        .Width         (64),
        .EnableVectors (1'b1),
        .TagType       (logic [3:0])
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .lane_result_i   (lane_result),
        .lane_status_i   (lane_status),
        .lane_mask_i     (lane_mask),
        .lane_ext_bit_i  (lane_ext),
        .lane_last_i     (lane_last),
        .vectorial_op_i  (vec_op),
        .tag_i           (tag_in),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .flush_i         (flush),
        .result_o        (result),
        .status_o        (status),
        .extension_bit_o (ext_out),
        .tag_o           (tag_out),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Output side: a handshake not cancelled by flush consumes one entry.
    always @(negedge clk) begin
        if (rst_ni && out_valid && out_ready && !flush) begin
            hs_count++;
            if (sb.size() == 0) begin
                n_checks++;
                $error("FAIL sb_underflow: observed %h expected none", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_result", result, e.res);
                chk("out_status", 64'(status), 64'(e.st));
                chk("out_ext", 64'(ext_out), 64'(e.ext));
                chk("out_tag", 64'(tag_out), 64'(e.tag));
            end
        end
    end

    task automatic beat(input logic [15:0] r, input logic [4:0] st,
                        input logic m, input logic e, input logic l,
                        input logic v, input logic [3:0] t);
        lane_result = r;
        lane_status = st;
        lane_mask   = m;
        lane_ext    = e;
        lane_last   = l;
        vec_op      = v;
        tag_in      = t;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic push(input logic [63:0] r, input logic [4:0] st,
                        input logic e, input logic [3:0] t);
        exp_t x;
        x.res = r;
        x.st  = st;
        x.ext = e;
        x.tag = t;
        sb.push_back(x);
    endtask

    initial begin
        int hs_before;
        rst_ni      = 1'b0;
        lane_result = '0;
        lane_status = '0;
        lane_mask   = 1'b0;
        lane_ext    = 1'b0;
        lane_last   = 1'b0;
        vec_op      = 1'b0;
        tag_in      = '0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_ext", 64'(ext_out), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        chk("rst_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Two beats into a vector, then asynchronous reset.
        beat(16'h1234, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
        beat(16'h5678, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
        chk("collect_busy", 64'(busy), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_status", 64'(status), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Full four-lane vector; later beats carry a different ext and tag.
        push(64'h4400_4200_4000_3C00, 5'b00000, 1'b1, 4'h5);
        beat(16'h3C00, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        beat(16'h4000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
        beat(16'h4200, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
        beat(16'h4400, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA);
        chk("vec4_latency", 64'(out_valid), 64'd1);
        chk("vec4_in_ready", 64'(in_ready), 64'd0);
        drain("vec4_wait");
        chk("vec4_idle", 64'(busy), 64'd0);

        // Scalar op: single beat completes, upper lanes boxed.
        push(64'hFFFF_FFFF_FFFF_3C00, 5'b10000, 1'b1, 4'h7);
        beat(16'h3C00, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
        chk("scalar_latency", 64'(out_valid), 64'd1);
        drain("scalar_wait");

        // Early last after two lanes.
        push(64'hFFFF_FFFF_2222_1111, 5'b00000, 1'b1, 4'h2);
        beat(16'h1111, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2);
        beat(16'h2222, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
        chk("early_latency", 64'(out_valid), 64'd1);
        drain("early_wait");

        // Status masking; fourth beat completes without last.
        push(64'h0004_0003_0002_0001, 5'b00011, 1'b0, 4'h4);
        beat(16'h0001, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
        beat(16'h0002, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4);
        beat(16'h0003, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
        beat(16'h0004, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
        chk("nowrap_full", 64'(out_valid), 64'd1);
        drain("mask_wait");

        // Stall in FULL, then flush together with out_ready.
        beat(16'h5555, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
        beat(16'h6666, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
        beat(16'h7777, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
        beat(16'h8888, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_result", result, 64'h8888_7777_6666_5555);
            @(posedge clk);
            #1;
        end
        hs_before = hs_count;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_no_hs", 64'(hs_count), 64'(hs_before));

        // Flush drops a simultaneous beat; next vector starts at lane 0.
        flush = 1'b1;
        beat(16'hDEAD, 5'b01000, 1'b1, 1'b1, 1'b0, 1'b1, 4'hE);
        flush = 1'b0;
        chk("flushbeat_busy", 64'(busy), 64'd0);
        push(64'h0000_0000_0000_ABCD, 5'b00000, 1'b0, 4'h6);
        beat(16'hABCD, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
        drain("after_flush_wait");

        @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
